leaf_stream_buffer: RTL and testbench

- Parametrised multi-channel elastic buffer on the user side of a leaf, between leaf_interface streams and the HLS operator's ap_vld/ap_ack ports.
- Gives each of NUM_CH channels an independent DEPTH-entry FIFO, decoupling operator stalls from the interface.
- Adds per-channel flush, live occupancy and a sticky high-watermark. The existing direct wiring has none of these.

---
 rtl/leaf_stream_buffer_if.sv | 29 ++
 rtl/leaf_stream_buffer.sv | 93 +++++++++
 tb/tb_leaf_stream_buffer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/leaf_stream_buffer_if.sv
// Stream-side bundle for leaf_stream_buffer: upstream push, downstream pop,
// per-channel flush and occupancy/high-water status.
interface leaf_stream_buffer_if #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_CH       = 2,
  parameter int DEPTH_BITS   = 2
);
  localparam int OCC_BITS = DEPTH_BITS + 1;

  logic [NUM_CH*PAYLOAD_BITS-1:0] din;
  logic [NUM_CH-1:0]              din_vld;
  logic [NUM_CH-1:0]              din_ack;
  logic [NUM_CH*PAYLOAD_BITS-1:0] dout;
  logic [NUM_CH-1:0]              dout_vld;
  logic [NUM_CH-1:0]              dout_ack;
  logic [NUM_CH-1:0]              flush;
  logic [NUM_CH*OCC_BITS-1:0]     occupancy;
  logic [NUM_CH*OCC_BITS-1:0]     high_water;

  modport master (
    output din, din_vld, dout_ack, flush,
    input  din_ack, dout, dout_vld, occupancy, high_water
  );

  modport slave (
    input  din, din_vld, dout_ack, flush,
    output din_ack, dout, dout_vld, occupancy, high_water
  );
endinterface

// File: rtl/leaf_stream_buffer.sv
// Multi-channel elastic buffer: one independent DEPTH-entry FIFO per channel
// with synchronous flush, live occupancy and a sticky high-water mark.
module leaf_stream_buffer #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_CH       = 2,
  parameter int DEPTH_BITS   = 2
) (
  input  logic                  clk_user,
  input  logic                  reset_n,
  leaf_stream_buffer_if.slave   bus
);
  localparam int DEPTH    = 2 ** DEPTH_BITS;
  localparam int OCC_BITS = DEPTH_BITS + 1;
  // A depth-1 FIFO still needs a 1-bit pointer; it simply stays at 0.
  localparam int PTR_W    = (DEPTH_BITS > 0) ? DEPTH_BITS : 1;

  logic [NUM_CH-1:0]              ack_v;
  logic [NUM_CH-1:0]              vld_v;
  logic [NUM_CH*PAYLOAD_BITS-1:0] dout_v;
  logic [NUM_CH*OCC_BITS-1:0]     occ_v;
  logic [NUM_CH*OCC_BITS-1:0]     hw_v;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [OCC_BITS-1:0]     occ;
    logic [OCC_BITS-1:0]     occ_nxt;
    logic [OCC_BITS-1:0]     hw;
    logic                    full;
    logic                    not_empty;
    logic                    push;
    logic                    pop;
    logic                    flush_c;

    assign flush_c   = bus.flush[c];
    assign not_empty = (occ != '0);
    assign full      = (occ == OCC_BITS'(DEPTH));
    assign pop       = not_empty & bus.dout_ack[c];
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign push      = bus.din_vld[c] & ~flush_c & (~full | pop);

    always_comb begin
      occ_nxt = occ;
      if (push && !pop) begin
        occ_nxt = occ + OCC_BITS'(1);
      end else if (pop && !push) begin
        occ_nxt = occ - OCC_BITS'(1);
      end
    end

    always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
        hw     <= '0;
      end else if (flush_c) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
        hw     <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= bus.din[c*PAYLOAD_BITS +: PAYLOAD_BITS];
          wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        end
        occ <= occ_nxt;
        if (occ_nxt > hw) begin
          hw <= occ_nxt;
        end
      end
    end

    assign ack_v[c]                              = push;
    assign vld_v[c]                              = not_empty;
    assign dout_v[c*PAYLOAD_BITS +: PAYLOAD_BITS] = mem[rd_ptr];
    assign occ_v[c*OCC_BITS +: OCC_BITS]          = occ;
    assign hw_v[c*OCC_BITS +: OCC_BITS]           = hw;
  end

  assign bus.din_ack    = ack_v;
  assign bus.dout_vld   = vld_v;
  assign bus.dout       = dout_v;
  assign bus.occupancy  = occ_v;
  assign bus.high_water = hw_v;
endmodule

// File: tb/tb_leaf_stream_buffer.sv
// Directed bench for leaf_stream_buffer (2 channels, 32-bit, depth 4).
module tb_leaf_stream_buffer;
  logic clk_user = 1'b0;
  logic reset_n  = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  leaf_stream_buffer_if #(.PAYLOAD_BITS(32), .NUM_CH(2), .DEPTH_BITS(2)) bus ();

  leaf_stream_buffer #(.PAYLOAD_BITS(32), .NUM_CH(2), .DEPTH_BITS(2)) dut (
    .clk_user (clk_user),
    .reset_n  (reset_n),
    .bus      (bus.slave)
  );

  always #5 clk_user = ~clk_user;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_user);
    #1;
  endtask

  initial begin
    bus.din      = '0;
    bus.din_vld  = '0;
    bus.dout_ack = '0;
    bus.flush    = '0;

    // 1. reset then idle
    repeat (3) @(posedge clk_user);
    #1 reset_n = 1'b1;
    #1;
    check_val("rst dout_vld", 32'(bus.dout_vld), 32'h0);
    check_val("rst din_ack", 32'(bus.din_ack), 32'h0);
    check_val("rst occupancy", 32'(bus.occupancy), 32'h0);
    check_val("rst high_water", 32'(bus.high_water), 32'h0);
    check_val("rst dout", bus.dout[31:0], 32'h0);
    tick();

    // 2. fill channel 0 with 0x11..0x55; only four fit
    for (int i = 0; i < 5; i++) begin
      bus.din[31:0]  = 32'h11 * (i + 1);
      bus.din_vld[0] = 1'b1;
      #1;
      check_val($sformatf("fill ack %0d", i), 32'(bus.din_ack[0]), (i < 4) ? 32'h1 : 32'h0);
      if (i > 0) check_val($sformatf("fill head %0d", i), bus.dout[31:0], 32'h11);
      tick();
      check_val($sformatf("fill occ %0d", i), 32'(bus.occupancy[2:0]), (i < 4) ? 32'(i + 1) : 32'h4);
    end
    check_val("fill hw", 32'(bus.high_water[2:0]), 32'h4);

    // 4. ch1 streams while ch0 is stalled full (0x55 still offered)
    for (int k = 0; k < 9; k++) begin
      bus.din[63:32] = 32'hA0 + 32'(k);
      bus.din_vld[1] = (k < 8);
      bus.dout_ack[1] = 1'b1;
      #1;
      if (k < 8) check_val($sformatf("ch1 ack %0d", k), 32'(bus.din_ack[1]), 32'h1);
      if (k > 0) begin
        check_val($sformatf("ch1 vld %0d", k), 32'(bus.dout_vld[1]), 32'h1);
        check_val($sformatf("ch1 dout %0d", k), bus.dout[63:32], 32'hA0 + 32'(k - 1));
      end
      check_val($sformatf("ch0 stalled ack %0d", k), 32'(bus.din_ack[0]), 32'h0);
      tick();
    end
    bus.din_vld[1]  = 1'b0;
    bus.dout_ack[1] = 1'b0;
    check_val("ch1 drained occ", 32'(bus.occupancy[5:3]), 32'h0);
    check_val("ch1 hw", 32'(bus.high_water[5:3]), 32'h1);
    check_val("ch0 untouched occ", 32'(bus.occupancy[2:0]), 32'h4);
    check_val("ch0 untouched head", bus.dout[31:0], 32'h11);

    // 3. full with simultaneous pop, then drain in order
    bus.din[31:0]   = 32'h55;
    bus.din_vld[0]  = 1'b1;
    bus.dout_ack[0] = 1'b1;
    #1;
    check_val("full pop ack", 32'(bus.din_ack[0]), 32'h1);
    tick();
    bus.din_vld[0] = 1'b0;
    check_val("full pop occ", 32'(bus.occupancy[2:0]), 32'h4);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val($sformatf("drain %0d", i), bus.dout[31:0], 32'h22 + 32'h11 * i);
      tick();
    end
    bus.dout_ack[0] = 1'b0;
    check_val("drain empty vld", 32'(bus.dout_vld[0]), 32'h0);
    check_val("drain hw sticky", 32'(bus.high_water[2:0]), 32'h4);

    // 5. flush with three entries held
    for (int i = 0; i < 3; i++) begin
      bus.din[31:0]  = 32'h61 + 32'(i);
      bus.din_vld[0] = 1'b1;
      tick();
    end
    check_val("pre-flush occ", 32'(bus.occupancy[2:0]), 32'h3);
    bus.din[31:0] = 32'h77;
    bus.flush[0]  = 1'b1;
    #1;
    check_val("flush ack", 32'(bus.din_ack[0]), 32'h0);
    tick();
    bus.flush[0]   = 1'b0;
    bus.din_vld[0] = 1'b0;
    check_val("flush occ", 32'(bus.occupancy[2:0]), 32'h0);
    check_val("flush hw", 32'(bus.high_water[2:0]), 32'h0);
    check_val("flush vld", 32'(bus.dout_vld[0]), 32'h0);
    bus.din[31:0]  = 32'h99;
    bus.din_vld[0] = 1'b1;
    #1;
    check_val("post-flush ack", 32'(bus.din_ack[0]), 32'h1);
    tick();
    bus.din_vld[0] = 1'b0;
    check_val("post-flush dout", bus.dout[31:0], 32'h99);
    check_val("post-flush vld", 32'(bus.dout_vld[0]), 32'h1);
    check_val("post-flush hw", 32'(bus.high_water[2:0]), 32'h1);

    // 6. async reset while ch1 holds two entries
    bus.din[63:32] = 32'hB1;
    bus.din_vld[1] = 1'b1;
    tick();
    bus.din[63:32] = 32'hB2;
    tick();
    bus.din_vld[1] = 1'b0;
    check_val("pre-reset occ1", 32'(bus.occupancy[5:3]), 32'h2);
    #2 reset_n = 1'b0;
    #1;
    check_val("async vld1", 32'(bus.dout_vld[1]), 32'h0);
    check_val("async occ1", 32'(bus.occupancy[5:3]), 32'h0);
    check_val("async hw1", 32'(bus.high_water[5:3]), 32'h0);
    check_val("async occ0", 32'(bus.occupancy[2:0]), 32'h0);
    check_val("async dout1", bus.dout[63:32], 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check_val("post-reset vld", 32'(bus.dout_vld), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
